cam_write_ctrl: RTL and testbench

Write-side controller for the 32-entry CAM. It accepts write, allocate and invalidate requests over a valid/ready handshake, decodes them into a one-hot per-entry write-enable pulse with broadcast data, and owns the per-entry valid bitmap. The read-side mux consumes the entry array this block writes and the valid bits it maintains. A response channel returns the entry index actually written and an error flag.

---
 rtl/cam_write_ctrl_pkg.sv | 20 ++
 rtl/cam_write_ctrl_if.sv | 27 ++
 rtl/cam_write_ctrl_free_enc.sv | 23 ++
 rtl/cam_write_ctrl.sv | 122 ++++++++++++
 tb/tb_cam_write_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cam_write_ctrl_pkg.sv
// Shared CAM types and default geometry.
// The read-side mux imports the same defaults.
package cam_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 32;

    typedef enum logic [1:0] {
        OP_WRITE_IDX   = 2'd0,
        OP_WRITE_ALLOC = 2'd1,
        OP_INVAL_IDX   = 2'd2,
        OP_INVAL_ALL   = 2'd3
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } cam_state_e;
endpackage

// File: rtl/cam_write_ctrl_if.sv
// Request/response handshake bundle for the CAM write controller.
interface cam_write_ctrl_if
    import cam_pkg::*;
#(
    parameter int DW = cam_pkg::DATA_WIDTH,
    parameter int AW = cam_pkg::ADDR_WIDTH
);
    logic          req_valid_i;
    logic          req_ready_o;
    cam_op_e       req_op_i;
    logic [AW-1:0] req_index_i;
    logic [DW-1:0] req_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [AW-1:0] rsp_index_o;
    logic          rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_index_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_index_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_index_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_index_o, rsp_err_o
    );
endinterface

// File: rtl/cam_write_ctrl_free_enc.sv
// Lowest-index free entry finder over the valid bitmap.
module cam_free_enc
    import cam_pkg::*;
#(
    parameter int DEPTH      = cam_pkg::DEPTH,
    parameter int ADDR_WIDTH = cam_pkg::ADDR_WIDTH
) (
    input  logic [DEPTH-1:0]      valid_i,
    output logic [ADDR_WIDTH-1:0] free_idx_o,
    output logic                  any_free_o
);
    // Scan high to low so the last hit is the lowest free index.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx_o = ADDR_WIDTH'(i);
                any_free_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cam_write_ctrl.sv
// CAM write-side controller: decodes requests into one-hot entry writes
// and owns the valid bitmap and occupancy count.
module cam_write_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = cam_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cam_pkg::ADDR_WIDTH,
    parameter int DEPTH      = cam_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cam_write_ctrl_if.slave       bus,
    output logic [DEPTH-1:0]      wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [DEPTH-1:0]      entry_valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

    cam_state_e            state_q, state_d;
    cam_op_e               op_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic [ADDR_WIDTH-1:0] rsp_idx_q, rsp_idx_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] free_idx;
    logic                  any_free;

    cam_free_enc #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_free_enc (
        .valid_i    (valid_q),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        count_d   = count_q;
        rsp_idx_d = rsp_idx_q;
        rsp_err_d = rsp_err_q;
        wr_en_o   = '0;
        case (state_q)
            ST_IDLE: if (bus.req_valid_i) state_d = ST_ISSUE;
            ST_ISSUE: begin
                state_d   = ST_RESP;
                rsp_err_d = 1'b0;
                rsp_idx_d = idx_q;
                case (op_q)
                    OP_WRITE_IDX: begin
                        wr_en_o[idx_q] = 1'b1;
                        valid_d[idx_q] = 1'b1;
                        if (!valid_q[idx_q]) count_d = count_q + ONE;
                    end
                    OP_WRITE_ALLOC: begin
                        rsp_idx_d = any_free ? free_idx : '0;
                        rsp_err_d = !any_free;
                        if (any_free) begin
                            wr_en_o[free_idx] = 1'b1;
                            valid_d[free_idx] = 1'b1;
                            count_d           = count_q + ONE;
                        end
                    end
                    OP_INVAL_IDX: begin
                        valid_d[idx_q] = 1'b0;
                        if (valid_q[idx_q]) count_d = count_q - ONE;
                    end
                    default: begin
                        valid_d   = '0;
                        count_d   = '0;
                        rsp_idx_d = '0;
                    end
                endcase
            end
            ST_RESP: if (bus.rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_WRITE_IDX;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rsp_idx_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            full_q    <= (count_d == FULL_CNT);
            empty_q   <= (count_d == '0);
            rsp_idx_q <= rsp_idx_d;
            rsp_err_q <= rsp_err_d;
            if (state_q == ST_IDLE && bus.req_valid_i) begin
                op_q   <= bus.req_op_i;
                idx_q  <= bus.req_index_i;
                data_q <= bus.req_data_i;
            end
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_index_o = rsp_idx_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign wr_data_o       = data_q;
    assign entry_valid_o   = valid_q;
    assign count_o         = count_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
endmodule

// File: tb/tb_cam_write_ctrl.sv
// Self-checking bench: vector table plus hand sequences, responses
// matched through a scoreboard queue.
module tb_cam_write_ctrl;
    import cam_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_en, wr_data, entry_valid;
    logic [5:0]  count;
    logic        full, empty;

    cam_write_ctrl_if bus();

    cam_write_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .wr_en_o       (wr_en),
        .wr_data_o     (wr_data),
        .entry_valid_o (entry_valid),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        cam_op_e     op;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] exp_wr_en;
        logic [4:0]  exp_idx;
        logic        exp_err;
        logic [31:0] exp_valid;
        int          exp_count;
    } vec_t;

    typedef struct {
        logic [4:0] idx;
        logic       err;
    } rsp_t;

    vec_t vecs[10];
    rsp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request and return just after the accepting edge (DUT in ISSUE).
    task automatic send(input cam_op_e op, input logic [4:0] idx, input logic [31:0] data);
        bit ok = 0;
        bus.req_op_i    = op;
        bus.req_index_i = idx;
        bus.req_data_i  = data;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic run_req(input cam_op_e op, input logic [4:0] idx, input logic [31:0] data,
                           input logic [31:0] exp_wr_en, input logic [4:0] exp_idx,
                           input logic exp_err, input logic [31:0] exp_valid, input int exp_count);
        int   lat = -1;
        rsp_t e;
        sb.push_back('{idx: exp_idx, err: exp_err});
        send(op, idx, data);
        @(negedge clk);
        chk("wr_en", wr_en, exp_wr_en);
        chk("wr_data", wr_data, data);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                lat = k;
                break;
            end
        end
        chk("rsp_latency", lat, 0);
        e = sb.pop_front();
        chk("rsp_index", bus.rsp_index_o, e.idx);
        chk("rsp_err", bus.rsp_err_o, e.err);
        chk("rsp_wr_en_zero", wr_en, 0);
        chk("req_ready_in_resp", bus.req_ready_o, 0);
        chk("entry_valid", entry_valid, exp_valid);
        chk("count", count, exp_count);
        chk("full", full, exp_count == 32);
        chk("empty", empty, exp_count == 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] m_valid;
        bit          seen;
        vecs[0] = '{OP_WRITE_IDX,   5'd5,  32'hDEADBEEF, 32'h0000_0020, 5'd5,  1'b0, 32'h0000_0020, 1};
        vecs[1] = '{OP_INVAL_ALL,   5'd0,  32'h0000_1111, 32'h0,         5'd0,  1'b0, 32'h0,         0};
        vecs[2] = '{OP_WRITE_ALLOC, 5'd17, 32'hA0A0_0000, 32'h0000_0001, 5'd0,  1'b0, 32'h0000_0001, 1};
        vecs[3] = '{OP_WRITE_ALLOC, 5'd0,  32'hA0A0_0001, 32'h0000_0002, 5'd1,  1'b0, 32'h0000_0003, 2};
        vecs[4] = '{OP_WRITE_ALLOC, 5'd0,  32'hA0A0_0002, 32'h0000_0004, 5'd2,  1'b0, 32'h0000_0007, 3};
        vecs[5] = '{OP_WRITE_IDX,   5'd3,  32'h3333_3333, 32'h0000_0008, 5'd3,  1'b0, 32'h0000_000F, 4};
        vecs[6] = '{OP_WRITE_IDX,   5'd3,  32'h3333_4444, 32'h0000_0008, 5'd3,  1'b0, 32'h0000_000F, 4};
        vecs[7] = '{OP_INVAL_IDX,   5'd9,  32'h9999_9999, 32'h0,         5'd9,  1'b0, 32'h0000_000F, 4};
        vecs[8] = '{OP_INVAL_IDX,   5'd1,  32'h1111_0000, 32'h0,         5'd1,  1'b0, 32'h0000_000D, 3};
        vecs[9] = '{OP_WRITE_ALLOC, 5'd30, 32'h5555_AAAA, 32'h0000_0002, 5'd1,  1'b0, 32'h0000_000F, 4};

        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = OP_WRITE_IDX;
        bus.req_index_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b1;
        #12;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_valid", entry_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_index", bus.rsp_index_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_req_ready", bus.req_ready_o, 1);

        foreach (vecs[i])
            run_req(vecs[i].op, vecs[i].idx, vecs[i].data, vecs[i].exp_wr_en,
                    vecs[i].exp_idx, vecs[i].exp_err, vecs[i].exp_valid, vecs[i].exp_count);

        // Fill every entry by index; entries 0..3 are already valid.
        m_valid = 32'h0000_000F;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b1;
            run_req(OP_WRITE_IDX, 5'(i), 32'h100 + 32'(i), 32'h1 << i, 5'(i), 1'b0,
                    m_valid, $countones(m_valid));
        end
        run_req(OP_WRITE_ALLOC, 5'd4, 32'hF011_F011, 32'h0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32);
        run_req(OP_INVAL_IDX,   5'd7, 32'h7,         32'h0, 5'd7, 1'b0, 32'hFFFF_FF7F, 31);
        run_req(OP_WRITE_ALLOC, 5'd0, 32'h7777_7777, 32'h0000_0080, 5'd7, 1'b0, 32'hFFFF_FFFF, 32);

        // Response back-pressure with a competing request held pending.
        bus.rsp_ready_i = 1'b0;
        sb.push_back('{idx: 5'd0, err: 1'b1});
        send(OP_WRITE_ALLOC, 5'd0, 32'hBAD0_0001);
        @(negedge clk);
        chk("stall_issue_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        bus.req_op_i    = OP_INVAL_IDX;
        bus.req_index_i = 5'd0;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", bus.rsp_valid_o, 1);
            chk("stall_req_ready", bus.req_ready_o, 0);
            chk("stall_rsp_err", bus.rsp_err_o, 1);
            chk("stall_rsp_index", bus.rsp_index_o, 0);
        end
        begin
            rsp_t e;
            e = sb.pop_front();
            chk("stall_sb_index", bus.rsp_index_o, e.idx);
            chk("stall_sb_err", bus.rsp_err_o, e.err);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_rsp_valid", bus.rsp_valid_o, 0);
        chk("stall_release_req_ready", bus.req_ready_o, 1);
        chk("stall_pending_not_taken", entry_valid, 32'hFFFF_FFFF);
        chk("stall_count", count, 32);
        @(posedge clk);
        #1;

        run_req(OP_INVAL_ALL, 5'd12, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 0);
        run_req(OP_WRITE_IDX, 5'd2, 32'h1234, 32'h4, 5'd2, 1'b0, 32'h4, 1);

        // Reset asserted while the request sits in ISSUE.
        send(OP_WRITE_IDX, 5'd20, 32'hCAFE_F00D);
        #1 chk("issue_wr_en_pre_rst", wr_en, 32'h0010_0000);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_valid", entry_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_full", full, 0);
        chk("midrst_rsp_valid", bus.rsp_valid_o, 0);
        chk("midrst_rsp_index", bus.rsp_index_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || wr_en != 0) seen = 1;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("post_rst_req_ready", bus.req_ready_o, 1);
        chk("post_rst_valid", entry_valid, 0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
